agc_timepulse_gen: RTL and testbench

- Upstream timing stage feeding the stage-branch/division-control module (A4): generates the twelve one-hot time pulses T01..T12 of each memory cycle time (MCT), with complements, plus the phase strobes PHS2_, PHS3_, PHS4, PHS4_ that A4 consumes.
- Sits between the master clock and every control module that gates on time pulses.
- Includes monitor-stop / single-step halting at the MCT boundary for bench and ground-support debug.

---
 rtl/agc_timing_pkg.sv | 33 +++
 rtl/agc_phase_ctr.sv | 33 +++
 rtl/agc_timepulse_gen.sv | 157 +++++++++++++++
 tb/tb_agc_timepulse_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/agc_timing_pkg.sv
// ============================================================================
// agc_timing_pkg : shared constants, FSM state type and one-hot helper for
//                  the AGC time-pulse generator.
// Revision: 1.0
// ============================================================================
`default_nettype none

package agc_timing_pkg;

    localparam int AGC_NUM_TP = 12;
    localparam int AGC_NUM_PH = 4;

    typedef enum logic [1:0] {
        TP_IDLE = 2'd0,
        TP_RUN  = 2'd1,
        TP_HALT = 2'd2
    } tp_state_t;

    // Bit (tp-1) set for tp in 1..12; out-of-range values give all zeros.
    function automatic logic [11:0] tp_onehot(input logic [3:0] tp);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) begin
            if (tp == 4'(i + 1)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/agc_phase_ctr.sv
// ============================================================================
// agc_phase_ctr : phase counter 1..NUM_PH with wrap indication ph_last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module agc_phase_ctr #(
    parameter int NUM_PH = 4,
    parameter int PH_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            adv,
    output logic [PH_W-1:0] ph,
    output logic            ph_last
);

    assign ph_last = (ph == PH_W'(NUM_PH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= PH_W'(NUM_PH);
        end else if (start) begin
            ph <= PH_W'(1);
        end else if (adv) begin
            ph <= ph_last ? PH_W'(1) : ph + PH_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/agc_timepulse_gen.sv
// ============================================================================
// agc_timepulse_gen : T01..T12 time pulses and phase strobes for each MCT.
//                     Monitor stop / single step enabled by AGC_MONSTOP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module agc_timepulse_gen
    import agc_timing_pkg::*;
#(
    parameter int NUM_TP = AGC_NUM_TP,
    parameter int NUM_PH = AGC_NUM_PH
) (
    input  logic CLOCK,
    input  logic rst,
    input  logic MSTP,
    input  logic MSTEP,
    output logic T01, output logic T02, output logic T03, output logic T04,
    output logic T05, output logic T06, output logic T07, output logic T08,
    output logic T09, output logic T10, output logic T11, output logic T12,
    output logic T01_, output logic T02_, output logic T03_, output logic T04_,
    output logic T05_, output logic T06_, output logic T07_, output logic T08_,
    output logic T09_, output logic T10_, output logic T11_, output logic T12_,
    output logic PHS2_,
    output logic PHS3_,
    output logic PHS4,
    output logic PHS4_,
    output logic MCTEND,
    output logic HALTED
);

    localparam int PH_W = $clog2(NUM_PH + 1);
    localparam int TP_W = 4;

    tp_state_t       state, next_state;
    logic [TP_W-1:0] tp;
    logic [PH_W-1:0] ph;
    logic            ph_last;
    logic            tp_last;
    logic            start;
    logic            adv;
    logic            run;
    logic            step_rise;
    logic [11:0]     t_vec;

    agc_phase_ctr #(
        .NUM_PH (NUM_PH),
        .PH_W   (PH_W)
    ) u_phase_ctr (
        .clk     (CLOCK),
        .rst     (rst),
        .start   (start),
        .adv     (adv),
        .ph      (ph),
        .ph_last (ph_last)
    );

    assign tp_last = (tp == TP_W'(NUM_TP));
    assign run     = (state == TP_RUN);

`ifdef AGC_MONSTOP_EN
    logic mstep_q;

    // Edge detector runs in every state so a rise outside HALT is consumed.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            mstep_q <= 1'b0;
        end else begin
            mstep_q <= MSTEP;
        end
    end

    assign step_rise = MSTEP & ~mstep_q;
    assign HALTED    = (state == TP_HALT);
`else
    logic unused_mon_inputs;
    assign unused_mon_inputs = MSTP ^ MSTEP;
    assign step_rise         = 1'b0;
    assign HALTED            = 1'b0;
`endif

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state <= TP_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        adv        = 1'b0;
        case (state)
            TP_IDLE: begin
                next_state = TP_RUN;
                start      = 1'b1;
            end
            TP_RUN: begin
`ifdef AGC_MONSTOP_EN
                // Halt only at the MCT boundary, holding counters at T12 PH4.
                if (tp_last && ph_last && MSTP) begin
                    next_state = TP_HALT;
                end else begin
                    adv = 1'b1;
                end
`else
                adv = 1'b1;
`endif
            end
`ifdef AGC_MONSTOP_EN
            TP_HALT: begin
                if (!MSTP || step_rise) begin
                    next_state = TP_RUN;
                    start      = 1'b1;
                end
            end
`endif
            default: begin
                next_state = TP_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            tp <= TP_W'(NUM_TP);
        end else if (start) begin
            tp <= TP_W'(1);
        end else if (adv && ph_last) begin
            tp <= tp_last ? TP_W'(1) : tp + TP_W'(1);
        end
    end

    assign t_vec  = run ? tp_onehot(tp) : 12'h000;
    assign PHS2_  = ~(run && (ph == PH_W'(2)));
    assign PHS3_  = ~(run && (ph == PH_W'(3)));
    assign PHS4   = run && (ph == PH_W'(4));
    assign PHS4_  = ~PHS4;
    assign MCTEND = run && tp_last && ph_last;

    assign T01 = t_vec[0];   assign T01_ = ~t_vec[0];
    assign T02 = t_vec[1];   assign T02_ = ~t_vec[1];
    assign T03 = t_vec[2];   assign T03_ = ~t_vec[2];
    assign T04 = t_vec[3];   assign T04_ = ~t_vec[3];
    assign T05 = t_vec[4];   assign T05_ = ~t_vec[4];
    assign T06 = t_vec[5];   assign T06_ = ~t_vec[5];
    assign T07 = t_vec[6];   assign T07_ = ~t_vec[6];
    assign T08 = t_vec[7];   assign T08_ = ~t_vec[7];
    assign T09 = t_vec[8];   assign T09_ = ~t_vec[8];
    assign T10 = t_vec[9];   assign T10_ = ~t_vec[9];
    assign T11 = t_vec[10];  assign T11_ = ~t_vec[10];
    assign T12 = t_vec[11];  assign T12_ = ~t_vec[11];

endmodule

`default_nettype wire

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen: cycle model feeding a scoreboard queue, plus a
// segment table with hand-derived end-of-segment pulse/halt values.
`default_nettype none

module tb_agc_timepulse_gen;

`ifdef AGC_MONSTOP_EN
    localparam bit MONSTOP = 1'b1;
`else
    localparam bit MONSTOP = 1'b0;
`endif
    localparam logic [29:0] RESET_VEC = {12'h000, 12'hFFF, 6'b110100};

    logic CLOCK, rst, MSTP, MSTEP;
    logic T01, T02, T03, T04, T05, T06, T07, T08, T09, T10, T11, T12;
    logic T01_, T02_, T03_, T04_, T05_, T06_, T07_, T08_, T09_, T10_, T11_, T12_;
    logic PHS2_, PHS3_, PHS4, PHS4_, MCTEND, HALTED;

    agc_timepulse_gen dut (
        .CLOCK(CLOCK), .rst(rst), .MSTP(MSTP), .MSTEP(MSTEP),
        .T01(T01), .T02(T02), .T03(T03), .T04(T04), .T05(T05), .T06(T06),
        .T07(T07), .T08(T08), .T09(T09), .T10(T10), .T11(T11), .T12(T12),
        .T01_(T01_), .T02_(T02_), .T03_(T03_), .T04_(T04_), .T05_(T05_), .T06_(T06_),
        .T07_(T07_), .T08_(T08_), .T09_(T09_), .T10_(T10_), .T11_(T11_), .T12_(T12_),
        .PHS2_(PHS2_), .PHS3_(PHS3_), .PHS4(PHS4), .PHS4_(PHS4_),
        .MCTEND(MCTEND), .HALTED(HALTED)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    logic [11:0] dut_t, dut_tn;
    logic [29:0] dut_vec;
    assign dut_t   = {T12, T11, T10, T09, T08, T07, T06, T05, T04, T03, T02, T01};
    assign dut_tn  = {T12_, T11_, T10_, T09_, T08_, T07_, T06_, T05_, T04_, T03_, T02_, T01_};
    assign dut_vec = {dut_t, dut_tn, PHS2_, PHS3_, PHS4, PHS4_, MCTEND, HALTED};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model: m_state 0=idle 1=run 2=halt, m_pos = cycle in MCT 0..47
    int m_state = 0;
    int m_pos   = 0;
    bit m_prev_step = 1'b0;
    logic [29:0] exp_q[$];

    function automatic void model_reset();
        m_state = 0;
        m_pos = 0;
        m_prev_step = 1'b0;
    endfunction

    function automatic void model_edge(input bit mstp_v, input bit mstep_v);
        bit rise;
        rise = mstep_v && !m_prev_step;
        m_prev_step = mstep_v;
        case (m_state)
            0: begin m_state = 1; m_pos = 0; end
            1: begin
                if (m_pos == 47) begin
                    if (MONSTOP && mstp_v) m_state = 2;
                    else m_pos = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            default: begin
                if (!mstp_v || rise) begin m_state = 1; m_pos = 0; end
            end
        endcase
    endfunction

    function automatic logic [29:0] model_out();
        logic [11:0] t;
        int ph;
        bit p2n, p3n, p4, mce;
        t = '0; p2n = 1; p3n = 1; p4 = 0; mce = 0;
        if (m_state == 1) begin
            t[m_pos / 4] = 1'b1;
            ph  = m_pos % 4 + 1;
            p2n = (ph != 2);
            p3n = (ph != 3);
            p4  = (ph == 4);
            mce = (m_pos == 47);
        end
        return {t, ~t, p2n, p3n, p4, ~p4, mce, (m_state == 2)};
    endfunction

    function automatic int dut_tidx();
        int idx;
        idx = 0;
        for (int i = 0; i < 12; i++) if (dut_t[i]) idx = i + 1;
        return idx;
    endfunction

    task automatic step(input bit mstp_v, input bit mstep_v);
        logic [29:0] exp_v;
        MSTP  = mstp_v;
        MSTEP = mstep_v;
        @(posedge CLOCK);
        model_edge(mstp_v, mstep_v);
        exp_q.push_back(model_out());
        #1;
        cyc++;
        exp_v = exp_q.pop_front();
        total++;
        if (dut_vec !== exp_v) begin
            bad++;
            $display("FAIL cycle%0d outputs: got=%h want=%h", cyc, dut_vec, exp_v);
        end
    endtask

    task automatic check_reset(input string name);
        total++;
        if (dut_vec !== RESET_VEC) begin
            bad++;
            $display("FAIL %s reset outputs: got=%h want=%h", name, dut_vec, RESET_VEC);
        end
    endtask

    task automatic async_reset(input string name);
        #2 rst = 1'b1;
        #1 check_reset(name);
        model_reset();
        MSTEP = 1'b0;
        @(posedge CLOCK);
        #1 check_reset({name, "_held"});
        rst = 1'b0;
    endtask

    typedef struct {
        bit mstp;
        int mstep_mode;   // 0: hold low, 1: hold high, 2: toggle every cycle
        int cycles;
        int exp_t;        // active Txx index at segment end, 0 = none
        bit exp_halt;
    } seg_t;

    seg_t tbl[$];

    initial begin
        rst = 1'b1; MSTP = 1'b0; MSTEP = 1'b0;

        tbl.push_back('{1'b0, 0, 1, 1, 1'b0});
        tbl.push_back('{1'b0, 0, 4, 2, 1'b0});
        tbl.push_back('{1'b0, 0, 43, 12, 1'b0});
        tbl.push_back('{1'b0, 0, 1, 1, 1'b0});
        tbl.push_back('{1'b0, 0, 480, 1, 1'b0});
`ifdef AGC_MONSTOP_EN
        tbl.push_back('{1'b0, 0, 17, 5, 1'b0});
        tbl.push_back('{1'b1, 0, 30, 12, 1'b0});
        tbl.push_back('{1'b1, 0, 1, 0, 1'b1});
        tbl.push_back('{1'b1, 0, 19, 0, 1'b1});
        tbl.push_back('{1'b0, 0, 1, 1, 1'b0});
        tbl.push_back('{1'b1, 0, 47, 12, 1'b0});
        tbl.push_back('{1'b1, 0, 1, 0, 1'b1});
        tbl.push_back('{1'b1, 1, 1, 1, 1'b0});
        tbl.push_back('{1'b1, 0, 10, 3, 1'b0});
        tbl.push_back('{1'b1, 1, 1, 3, 1'b0});
        tbl.push_back('{1'b1, 0, 36, 12, 1'b0});
        tbl.push_back('{1'b1, 0, 1, 0, 1'b1});
        tbl.push_back('{1'b1, 0, 5, 0, 1'b1});
        tbl.push_back('{1'b0, 1, 1, 1, 1'b0});
        tbl.push_back('{1'b0, 0, 3, 1, 1'b0});
`else
        tbl.push_back('{1'b1, 2, 240, 1, 1'b0});
        tbl.push_back('{1'b1, 0, 47, 12, 1'b0});
        tbl.push_back('{1'b1, 0, 1, 1, 1'b0});
`endif

        repeat (2) @(posedge CLOCK);
        #1 check_reset("power_on");
        rst = 1'b0;
        model_reset();

        foreach (tbl[s]) begin
            for (int c = 0; c < tbl[s].cycles; c++) begin
                step(tbl[s].mstp, (tbl[s].mstep_mode == 2) ? c[0] : (tbl[s].mstep_mode == 1));
            end
            total++;
            if (dut_tidx() != tbl[s].exp_t || HALTED !== tbl[s].exp_halt) begin
                bad++;
                $display("FAIL seg%0d end: got T=%0d halted=%b want T=%0d halted=%b",
                         s, dut_tidx(), HALTED, tbl[s].exp_t, tbl[s].exp_halt);
            end
        end

        // Asynchronous reset at T07 PH3 (MCT position 26).
        for (int i = 0; i < 60 && !(m_state == 1 && m_pos == 26); i++) step(1'b0, 1'b0);
        total++;
        if (!(T07 === 1'b1 && PHS3_ === 1'b0)) begin
            bad++;
            $display("FAIL reach_t07ph3: got T07=%b PHS3_=%b want T07=1 PHS3_=0", T07, PHS3_);
        end
        async_reset("rst_t07ph3");
        step(1'b0, 1'b0);
        total++;
        if (T01 !== 1'b1) begin
            bad++;
            $display("FAIL t01_after_rst: got T01=%b want 1", T01);
        end
        repeat (50) step(1'b0, 1'b0);

`ifdef AGC_MONSTOP_EN
        // Asynchronous reset while halted discards the halt and any step.
        for (int i = 0; i < 60 && m_state != 2; i++) step(1'b1, 1'b0);
        total++;
        if (HALTED !== 1'b1) begin
            bad++;
            $display("FAIL reach_halt: got HALTED=%b want 1", HALTED);
        end
        async_reset("rst_halt");
        step(1'b1, 1'b0);
        total++;
        if (T01 !== 1'b1 || HALTED !== 1'b0) begin
            bad++;
            $display("FAIL t01_after_halt_rst: got T01=%b HALTED=%b want 1 0", T01, HALTED);
        end
        repeat (60) step(1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
